// File: rtl/data_mem_resp.sv
// Word-addressed data memory behind a valid/ready request and response handshake.
// One request is in flight at a time; the response follows a fixed number of wait cycles.
module data_mem_resp #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LATENCY    = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_be_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o
);

    localparam int unsigned Depth  = 2 ** ADDR_WIDTH;
    localparam logic [2:0]  LatCnt = 3'(LATENCY);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e                 state_q, state_d;
    logic [2:0]             cnt_q, cnt_d;
    logic                   resp_valid_q, resp_valid_d;
    logic                   resp_err_q, resp_err_d;
    logic [31:0]            resp_rdata_q, resp_rdata_d;
    logic [31:0]            mem_q [Depth];

    logic                   accept;
    logic                   addr_err;
    logic                   store_en;
    logic [ADDR_WIDTH-1:0]  word_idx;

    assign req_ready_o  = (state_q == StIdle);
    assign accept       = req_valid_i && req_ready_o;
    assign word_idx     = req_addr_i[ADDR_WIDTH+1:2];
    assign addr_err     = (req_addr_i[1:0] != 2'b00) ||
                          ((req_addr_i >> (ADDR_WIDTH + 2)) != 32'd0);
    // Reset wins over a same-cycle accept, so a store must not commit then.
    assign store_en     = !rst_i && accept && req_we_i && !addr_err;

    assign resp_valid_o = resp_valid_q;
    assign resp_err_o   = resp_err_q;
    assign resp_rdata_o = resp_rdata_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        resp_valid_d = resp_valid_q;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    // Load data is captured at the accept edge and held until the handshake.
                    resp_err_d   = addr_err;
                    resp_rdata_d = (!req_we_i && !addr_err) ? mem_q[word_idx] : 32'd0;
                    if (LATENCY == 0) begin
                        state_d      = StResp;
                        resp_valid_d = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = LatCnt;
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d      = StResp;
                    resp_valid_d = 1'b1;
                end
            end
            StResp: begin
                if (resp_ready_i) begin
                    state_d      = StIdle;
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = 32'd0;
                end
            end
            default: begin
                state_d      = StIdle;
                resp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            cnt_q        <= 3'd0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    // Memory contents survive reset.
    always_ff @(posedge clk_i) begin
        if (store_en) begin
            for (int b = 0; b < 4; b++) begin
                if (req_be_i[b]) begin
                    mem_q[word_idx][8*b +: 8] <= req_wdata_i[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_resp.sv
// Scoreboard bench for data_mem_resp: one instance at LATENCY=2, one at LATENCY=0.
module tb_data_mem_resp;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    logic        a_req_valid, a_req_ready, a_req_we, a_resp_valid, a_resp_ready, a_resp_err;
    logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata;
    logic [3:0]  a_req_be;

    logic        b_req_valid, b_req_ready, b_req_we, b_resp_valid, b_resp_ready, b_resp_err;
    logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;
    logic [3:0]  b_req_be;

    logic [31:0] mdl [2][1024];
    exp_t        a_q[$];
    exp_t        b_q[$];
    exp_t        a_pop, b_pop, hold_e;

    assign b_resp_ready = 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_resp #(.ADDR_WIDTH(10), .LATENCY(2)) u_dut_a (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (a_req_valid),
        .req_ready_o (a_req_ready),
        .req_we_i    (a_req_we),
        .req_addr_i  (a_req_addr),
        .req_wdata_i (a_req_wdata),
        .req_be_i    (a_req_be),
        .resp_valid_o(a_resp_valid),
        .resp_ready_i(a_resp_ready),
        .resp_rdata_o(a_resp_rdata),
        .resp_err_o  (a_resp_err)
    );

    data_mem_resp #(.ADDR_WIDTH(10), .LATENCY(0)) u_dut_b (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (b_req_valid),
        .req_ready_o (b_req_ready),
        .req_we_i    (b_req_we),
        .req_addr_i  (b_req_addr),
        .req_wdata_i (b_req_wdata),
        .req_be_i    (b_req_be),
        .resp_valid_o(b_resp_valid),
        .resp_ready_i(b_resp_ready),
        .resp_rdata_o(b_resp_rdata),
        .resp_err_o  (b_resp_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference behaviour: error decode, byte-enabled store, load result.
    task automatic model_req(input int d, input string tag, input logic we,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] be, output exp_t e);
        logic       err;
        logic [9:0] idx;
        err     = (addr[1:0] != 2'b00) || ((addr >> 12) != 32'd0);
        idx     = addr[11:2];
        e.tag   = tag;
        e.err   = err;
        e.cyc   = cyc;
        e.rdata = 32'd0;
        if (!err && we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mdl[d][idx][8*b +: 8] = wdata[8*b +: 8];
            end
        end
        if (!err && !we) e.rdata = mdl[d][idx];
    endtask

    always @(negedge clk) begin
        if (a_resp_valid && a_resp_ready) begin
            if (a_q.size() == 0) begin
                check_eq("a_spurious_resp", 32'(a_resp_valid), 32'd0);
            end else begin
                a_pop = a_q.pop_front();
                check_eq({a_pop.tag, "_rdata"}, a_resp_rdata, a_pop.rdata);
                check_eq({a_pop.tag, "_err"}, 32'(a_resp_err), 32'(a_pop.err));
            end
        end
    end

    always @(negedge clk) begin
        if (b_resp_valid) begin
            if (b_q.size() == 0) begin
                check_eq("b_spurious_resp", 32'(b_resp_valid), 32'd0);
            end else begin
                b_pop = b_q.pop_front();
                check_eq({b_pop.tag, "_rdata"}, b_resp_rdata, b_pop.rdata);
                check_eq({b_pop.tag, "_err"}, 32'(b_resp_err), 32'(b_pop.err));
                check_eq({b_pop.tag, "_lat"}, 32'(cyc), 32'(b_pop.cyc + 1));
            end
        end
    end

    task automatic a_txn(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
        int   n;
        exp_t e;
        n = 0;
        while (!a_req_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check_eq({tag, "_rdy"}, 32'(a_req_ready), 32'd1);
        a_req_valid = 1'b1;
        a_req_we    = we;
        a_req_addr  = addr;
        a_req_wdata = wdata;
        a_req_be    = be;
        model_req(0, tag, we, addr, wdata, be, e);
        a_q.push_back(e);
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        check_eq({tag, "_busy"}, 32'(a_req_ready), 32'd0);
        n = 1;
        while (!a_resp_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check_eq({tag, "_lat"}, 32'(n), 32'd3);
        a_resp_ready = 1'b1;
        @(posedge clk); #1;
        a_resp_ready = 1'b0;
        check_eq({tag, "_idle"}, 32'(a_resp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int last;
        exp_t e;
        rst = 1'b1;
        a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_wdata = '0;
        a_req_be = '0; a_resp_ready = 1'b0;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0;
        b_req_be = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_eq("rst_req_ready", 32'(a_req_ready), 32'd1);
        check_eq("rst_resp_valid", 32'(a_resp_valid), 32'd0);
        check_eq("rst_resp_err", 32'(a_resp_err), 32'd0);
        check_eq("rst_resp_rdata", a_resp_rdata, 32'd0);
        check_eq("rst_b_req_ready", 32'(b_req_ready), 32'd1);

        a_txn("st10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        a_txn("ld10", 1'b0, 32'h10, 32'h0, 4'h0);
        a_txn("st20", 1'b1, 32'h20, 32'h11223344, 4'hF);
        a_txn("st20_be5", 1'b1, 32'h20, 32'hAABBCCDD, 4'h5);
        a_txn("ld20", 1'b0, 32'h20, 32'h0, 4'h0);
        a_txn("ld_mis", 1'b0, 32'h13, 32'h0, 4'h0);
        a_txn("ld_oor", 1'b0, 32'h1000, 32'h0, 4'h0);
        a_txn("st_mis", 1'b1, 32'h11, 32'h55555555, 4'hF);
        a_txn("st_oor", 1'b1, 32'h1040, 32'h12345678, 4'hF);
        a_txn("ld10_after_err", 1'b0, 32'h10, 32'h0, 4'h0);
        a_txn("st20_be0", 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0);
        a_txn("ld20_after_be0", 1'b0, 32'h20, 32'h0, 4'h0);

        // Response held off while a new request is presented and early resp_ready is ignored.
        a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 32'h10; a_req_be = 4'h0;
        model_req(0, "hold", 1'b0, 32'h10, 32'h0, 4'h0, hold_e);
        a_q.push_back(hold_e);
        @(posedge clk); #1;
        a_req_valid = 1'b0; a_resp_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("hold_wait_valid", 32'(a_resp_valid), 32'd0);
        @(posedge clk); #1;
        a_resp_ready = 1'b0;
        a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'h10;
        a_req_wdata = 32'h0; a_req_be = 4'hF;
        for (int i = 0; i < 5; i++) begin
            check_eq("hold_valid", 32'(a_resp_valid), 32'd1);
            check_eq("hold_rdata", a_resp_rdata, hold_e.rdata);
            check_eq("hold_req_ready", 32'(a_req_ready), 32'd0);
            @(posedge clk); #1;
        end
        a_req_valid = 1'b0; a_resp_ready = 1'b1;
        @(posedge clk); #1;
        a_resp_ready = 1'b0;
        a_txn("hold_reread", 1'b0, 32'h10, 32'h0, 4'h0);

        // Reset during WAIT drops the response; earlier store persists.
        a_txn("st30", 1'b1, 32'h30, 32'hCAFEF00D, 4'hF);
        a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 32'h30;
        @(posedge clk); #1;
        a_req_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("rst_wait_ready", 32'(a_req_ready), 32'd1);
        check_eq("rst_wait_valid", 32'(a_resp_valid), 32'd0);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (a_resp_valid) n++;
            @(posedge clk); #1;
        end
        check_eq("rst_no_resp", 32'(n), 32'd0);
        a_txn("rst_reread", 1'b0, 32'h30, 32'h0, 4'h0);

        // Reset in the same cycle as an accepted store: store must not land.
        a_txn("st38", 1'b1, 32'h38, 32'h00000001, 4'hF);
        a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'h38;
        a_req_wdata = 32'h00000002; a_req_be = 4'hF; rst = 1'b1;
        @(posedge clk); #1;
        a_req_valid = 1'b0; rst = 1'b0;
        check_eq("rst_accept_ready", 32'(a_req_ready), 32'd1);
        a_txn("ld38", 1'b0, 32'h38, 32'h0, 4'h0);

        // LATENCY=0 instance: continuous requests, resp_ready tied high.
        b_req_valid = 1'b1;
        last = 0;
        for (int i = 0; i < 9; i++) begin
            b_req_we    = (i < 4);
            b_req_addr  = (i < 4) ? 32'(32'h40 + 4 * i) :
                          (i < 8) ? 32'(32'h40 + 4 * (i - 4)) : 32'h41;
            b_req_wdata = 32'hA0B00000 + 32'(i);
            b_req_be    = 4'hF;
            n = 0;
            while (!b_req_ready && n < 10) begin
                @(posedge clk); #1; n++;
            end
            check_eq("b_rdy", 32'(b_req_ready), 32'd1);
            @(negedge clk);
            model_req(1, $sformatf("b%0d", i), b_req_we, b_req_addr, b_req_wdata, b_req_be, e);
            b_q.push_back(e);
            if (i > 0) check_eq("b_accept_gap", 32'(cyc - last), 32'd2);
            last = cyc;
            @(posedge clk); #1;
        end
        b_req_valid = 1'b0;

        repeat (5) @(posedge clk);
        #1;
        check_eq("a_queue_empty", 32'(a_q.size()), 32'd0);
        check_eq("b_queue_empty", 32'(b_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, word-address width; memory holds 2**ADDR_WIDTH 32-bit words.
REQ-002 Parameter LATENCY, default 2, wait cycles between request accept and response (legal range 0..7).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data.
REQ-010 req_be  input  4  byte enables for stores; bit i covers bits [8i+7:8i].
REQ-011 resp_valid  output  1  response available.
REQ-012 resp_ready  input  1  initiator accepts the response.
REQ-013 resp_rdata  output  32  load data; 0 for stores and errors.
REQ-014 resp_err  output  1  request was misaligned or out of range.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-016 req_ready SHALL be 1 only in IDLE, combinationally from state.
REQ-017 Accept = req_valid && req_ready; on accept, req_we, req_addr, req_wdata and req_be SHALL be registered.
REQ-018 On accept, IDLE SHALL go to WAIT with wait counter = LATENCY, or directly to RESP if LATENCY = 0.
REQ-019 In WAIT, the counter SHALL decrement each cycle; when it reaches 1 the next state SHALL be RESP, so resp_valid first asserts exactly LATENCY+1 cycles after the accept edge.
REQ-020 Errors: req_addr[1:0] != 0, or req_addr[31:ADDR_WIDTH+2] != 0, SHALL set resp_err = 1 and resp_rdata = 0, and SHALL NOT modify memory.
REQ-021 A valid store SHALL update only the enabled bytes of word req_addr[ADDR_WIDTH+1:2] at the accept edge; req_be = 0 completes with no change and no error.
REQ-022 A valid load SHALL capture the addressed word at the accept edge; a load SHALL return data from every store whose response completed earlier.
REQ-023 In RESP, resp_valid SHALL be 1 and resp_rdata/resp_err SHALL be held stable until resp_valid && resp_ready.
REQ-024 On the response handshake the FSM SHALL return to IDLE; accepting a new request takes at least one further cycle (no overlap).
REQ-025 resp_ready asserted outside RESP SHALL be ignored; req_valid outside IDLE SHALL be ignored and the request SHALL NOT be captured.
REQ-026 resp_valid SHALL be 0 in IDLE and WAIT.

Reset
REQ-027 When rst = 1 at a clock edge: state = IDLE, counter = 0, resp_valid = 0, resp_err = 0, resp_rdata = 0; req_ready = 1 from the next cycle.
REQ-028 Reset SHALL take priority over any accept or handshake in the same cycle; an in-flight request is discarded with no response.
REQ-029 Memory contents SHALL NOT be cleared by reset; a store committed before reset SHALL persist.

Verification
REQ-030 Store 0xDEADBEEF at 0x10 with be=0xF, then load 0x10 -> rdata=0xDEADBEEF, err=0; each resp_valid 3 cycles after accept (LATENCY=2).
REQ-031 Word 0x20 = 0x11223344; store 0xAABBCCDD with be=0x5, then load -> 0x11BB33DD.
REQ-032 Load 0x13 (misaligned) and load 0x1000 (out of range, ADDR_WIDTH=10) -> err=1, rdata=0; memory unchanged.
REQ-033 Hold resp_ready=0 for 5 cycles in RESP -> resp_valid and resp_rdata stable; req_ready=0 and a concurrent req_valid is ignored.
REQ-034 Assert rst during WAIT -> no response; req_ready=1 the next cycle; a store completed before reset still reads back.
REQ-035 Build with LATENCY=0 -> resp_valid asserts one cycle after accept; back-to-back requests are accepted every 2 cycles with resp_ready tied to 1.
